// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
// SERIAL_CMP_CODE_CHECK_EN (see top) decides whether code_illegal is used.
package serial_cmp_pkg;

  typedef enum logic {IDLE, CMP} cmp_state_t;

  typedef enum logic [1:0] {RES_EQ, RES_GT, RES_LT} cmp_res_t;

  // AsB wins over AiB, AiB wins over AeB; an all-zero code reads as equal.
  function automatic cmp_res_t decode_code(input logic AeB, input logic AsB, input logic AiB);
    cmp_res_t res;
    res = RES_EQ;
    if (AsB) begin
      res = RES_GT;
    end else if (AiB) begin
      res = RES_LT;
    end else if (AeB) begin
      res = RES_EQ;
    end
    return res;
  endfunction

  // A well-formed cell output is exactly one-hot.
  function automatic logic code_illegal(input logic AeB, input logic AsB, input logic AiB);
    logic [2:0] code;
    code = {AeB, AsB, AiB};
    return !((code == 3'b100) || (code == 3'b010) || (code == 3'b001));
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Bit-code input and result bundle between the 1-bit comparator cell
// side (master) and the serial accumulator (slave).
interface serial_magnitude_comparator_if;
  logic start;
  logic bit_valid;
  logic AeB;
  logic AsB;
  logic AiB;
  logic busy;
  logic res_valid;
  logic res_eq;
  logic res_gt;
  logic res_lt;
  logic code_err;

  modport master (
    output start, bit_valid, AeB, AsB, AiB,
    input  busy, res_valid, res_eq, res_gt, res_lt, code_err
  );

  modport slave (
    input  start, bit_valid, AeB, AsB, AiB,
    output busy, res_valid, res_eq, res_gt, res_lt, code_err
  );
endinterface

// File: rtl/serial_magnitude_comparator_bitcnt.sv
// Bit position counter for the serial comparator: load wins over clear,
// clear wins over increment. lastBit flags the final bit position.
module serial_cmp_bitcnt #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [CNT_W-1:0] ldVal,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             lastBit
);

  // Counter register with load/clear/increment priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ldVal;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign lastBit = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator accumulator. Takes one {AeB,AsB,AiB}
// code per sampled cycle, MSB first, and reports A==B / A>B / A<B after
// WIDTH bits with a one-cycle res_valid pulse.
// Optional macro SERIAL_CMP_CODE_CHECK_EN builds the sticky code_err check.
//
//   state | meaning
//   IDLE  | no word in progress, results held from the last word
//   CMP   | word in progress, counting sampled bits
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic                          clk,
  input logic                          rst_n,
  serial_magnitude_comparator_if.slave cmpBus
);

  cmp_state_t state, stateNext;
  logic       decided, decidedNext;
  cmp_res_t   decDir, decDirNext;
  logic       resValid, resValidNext;
  logic       resEq, resEqNext;
  logic       resGt, resGtNext;
  logic       resLt, resLtNext;

  logic             cntLd;
  logic             cntClr;
  logic             cntInc;
  logic [CNT_W-1:0] cntLdVal;
  logic [CNT_W-1:0] cnt;
  logic             lastBit;

  cmp_res_t bitRes;
  logic     wordDecided;
  cmp_res_t wordDir;

  serial_cmp_bitcnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bitcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld      (cntLd),
    .ldVal   (cntLdVal),
    .clr     (cntClr),
    .inc     (cntInc),
    .cnt     (cnt),
    .lastBit (lastBit)
  );

  assign bitRes = decode_code(cmpBus.AeB, cmpBus.AsB, cmpBus.AiB);

  // Decision including the current bit: an earlier decision is never overridden.
  assign wordDecided = decided | (bitRes != RES_EQ);
  assign wordDir     = decided ? decDir : bitRes;

  // A start-cycle bit is the MSB, so the counter loads 1 instead of 0.
  assign cntLdVal = CNT_W'(cmpBus.bit_valid);

  // FSM state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      decided  <= 1'b0;
      decDir   <= RES_EQ;
      resValid <= 1'b0;
      resEq    <= 1'b0;
      resGt    <= 1'b0;
      resLt    <= 1'b0;
    end else begin
      state    <= stateNext;
      decided  <= decidedNext;
      decDir   <= decDirNext;
      resValid <= resValidNext;
      resEq    <= resEqNext;
      resGt    <= resGtNext;
      resLt    <= resLtNext;
    end
  end

  // Next-state, decision tracking and completion; start overrides everything.
  always_comb begin
    stateNext    = state;
    decidedNext  = decided;
    decDirNext   = decDir;
    resValidNext = 1'b0;
    resEqNext    = resEq;
    resGtNext    = resGt;
    resLtNext    = resLt;
    cntLd        = 1'b0;
    cntClr       = 1'b0;
    cntInc       = 1'b0;

    if (cmpBus.start) begin
      stateNext = CMP;
      cntLd     = 1'b1;
      resEqNext = 1'b0;
      resGtNext = 1'b0;
      resLtNext = 1'b0;
      if (cmpBus.bit_valid) begin
        decidedNext = (bitRes != RES_EQ);
        decDirNext  = bitRes;
      end else begin
        decidedNext = 1'b0;
        decDirNext  = RES_EQ;
      end
    end else if ((state == CMP) && cmpBus.bit_valid) begin
      if (lastBit) begin
        stateNext    = IDLE;
        cntClr       = 1'b1;
        resValidNext = 1'b1;
        resEqNext    = !wordDecided;
        resGtNext    = wordDecided && (wordDir == RES_GT);
        resLtNext    = wordDecided && (wordDir == RES_LT);
        decidedNext  = 1'b0;
        decDirNext   = RES_EQ;
      end else begin
        cntInc      = 1'b1;
        decidedNext = wordDecided;
        decDirNext  = wordDir;
      end
    end
  end

  assign cmpBus.busy      = (state == CMP);
  assign cmpBus.res_valid = resValid;
  assign cmpBus.res_eq    = resEq;
  assign cmpBus.res_gt    = resGt;
  assign cmpBus.res_lt    = resLt;

`ifdef SERIAL_CMP_CODE_CHECK_EN
  logic codeErr;
  logic bitIllegal;

  assign bitIllegal = code_illegal(cmpBus.AeB, cmpBus.AsB, cmpBus.AiB);

  // Sticky illegal-code flag, cleared by start and kept after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codeErr <= 1'b0;
    end else if (cmpBus.start) begin
      codeErr <= cmpBus.bit_valid & bitIllegal;
    end else if ((state == CMP) && cmpBus.bit_valid) begin
      codeErr <= codeErr | bitIllegal;
    end
  end

  assign cmpBus.code_err = codeErr;
`else
  assign cmpBus.code_err = 1'b0;
`endif

endmodule
